ffi_gamma_scheduler: RTL and testbench

Sequences feed-forward inhibition (FFI) across one gamma cycle of GAMMA_LEN time steps for a column.
- Accepts one active-low spike volley per time step over a valid/ready handshake.
- Accumulates the spike count across the gamma cycle.
- Passes volleys unchanged while the cumulative count stays below a programmable threshold. Once the threshold is reached, it forces all-ones (no spikes) for the rest of the gamma cycle.
- Sits between the spike-generation stage and the downstream neuron/WTA stage, and owns the runtime FFI threshold.

---
 rtl/ffi_gamma_scheduler.sv | 154 +++++++++++++++
 tb/tb_ffi_gamma_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffi_gamma_scheduler.sv
// Feed-forward inhibition sequencer over one gamma cycle of volleys.
// Optional FFI_STATS_EN adds inhib_count and last_count outputs.
module ffi_gamma_scheduler #(
  parameter int NUM_SPIKES      = 16,
  parameter int GAMMA_LEN       = 8,
  parameter int FFI_MAX_DEFAULT = 4,
  localparam int CNT_W = $clog2(NUM_SPIKES*GAMMA_LEN+1),
  localparam int SW    = $clog2(GAMMA_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  cfg_we,
  input  logic [CNT_W-1:0]      cfg_ffi_max,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_SPIKES-1:0] in_spikes_l,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_SPIKES-1:0] out_spikes_l,
  output logic [SW-1:0]         step_idx,
  output logic                  busy,
  output logic                  inhibited,
  output logic                  gamma_done
`ifdef FFI_STATS_EN
  ,
  output logic [15:0]           inhib_count,
  output logic [CNT_W-1:0]      last_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_INHIBIT
  } state_t;

  localparam logic [SW-1:0] LAST = SW'(GAMMA_LEN-1);
  localparam logic [CNT_W-1:0] DEF_MAX = CNT_W'(FFI_MAX_DEFAULT);

  state_t                r_state;
  logic [CNT_W-1:0]      r_c;
  logic [CNT_W-1:0]      r_ffi_max;
  logic [SW-1:0]         r_step;
  logic                  r_ov;
  logic                  r_inh;
  logic                  r_done;
  logic [NUM_SPIKES-1:0] r_out;

  logic [CNT_W-1:0]      w_n;
  logic [CNT_W:0]        w_sum;
  logic                  w_pass;
  logic                  w_fire;
  logic                  w_last;
  logic                  w_acc;
  logic [NUM_SPIKES-1:0] w_out;
  logic [CNT_W-1:0]      w_c_nxt;

  // spikes are active-low, so count the zero bits
  always_comb begin
    w_n = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      w_n = w_n + {{(CNT_W-1){1'b0}}, ~in_spikes_l[i]};
    end
  end

  assign w_sum   = {1'b0, r_c} + {1'b0, w_n};
  assign w_pass  = (r_state == ST_RUN) &&
                   (w_sum < {1'b0, r_ffi_max});
  assign w_fire  = (r_state == ST_RUN) && !w_pass;
  assign w_out   = w_pass ? in_spikes_l : '1;
  assign w_c_nxt = w_pass ? w_sum[CNT_W-1:0] : r_c;
  assign w_last  = (r_step == LAST);
  assign w_acc   = in_valid && in_ready;

  assign in_ready     = (r_state != ST_IDLE) &&
                        (!r_ov || out_ready);
  assign out_valid    = r_ov;
  assign out_spikes_l = r_out;
  assign step_idx     = r_step;
  assign busy         = (r_state != ST_IDLE);
  assign inhibited    = r_inh;
  assign gamma_done   = r_done;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= ST_IDLE;
      r_c       <= '0;
      r_ffi_max <= DEF_MAX;
      r_step    <= '0;
      r_ov      <= 1'b0;
      r_inh     <= 1'b0;
      r_done    <= 1'b0;
      r_out     <= '1;
    end else begin
      r_done <= 1'b0;
      if (w_acc) begin
        r_ov  <= 1'b1;
        r_out <= w_out;
      end else if (out_ready) begin
        r_ov <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (cfg_we) r_ffi_max <= cfg_ffi_max;
          if (start) begin
            r_state <= ST_RUN;
            r_c     <= '0;
            r_step  <= '0;
            r_inh   <= 1'b0;
          end
        end
        ST_RUN, ST_INHIBIT: begin
          if (w_acc) begin
            r_c <= w_c_nxt;
            if (w_fire) begin
              r_state <= ST_INHIBIT;
              r_inh   <= 1'b1;
            end
            // the final step overrides any inhibit transition
            if (w_last) begin
              r_step  <= '0;
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FFI_STATS_EN
  logic [15:0]      r_icnt;
  logic [CNT_W-1:0] r_last_c;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_icnt   <= '0;
      r_last_c <= '0;
    end else if (w_acc && w_last) begin
      r_last_c <= w_c_nxt;
      if ((r_inh || w_fire) && (r_icnt != 16'hFFFF))
        r_icnt <= r_icnt + 16'd1;
    end
  end

  assign inhib_count = r_icnt;
  assign last_count  = r_last_c;
`endif

endmodule

// File: tb/tb_ffi_gamma_scheduler.sv
// Self-checking bench for ffi_gamma_scheduler.
// Table vectors, directed corner sequences and a random model run.
module tb_ffi_gamma_scheduler;

  localparam int NS = 16;
  localparam int GL = 8;
  localparam int CW = $clog2(NS*GL+1);
  localparam int SW = $clog2(GL);

  logic          clk;
  logic          rst_l;
  logic          cfg_we;
  logic [CW-1:0] cfg_ffi_max;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [NS-1:0] in_spikes_l;
  logic          out_valid;
  logic          out_ready;
  logic [NS-1:0] out_spikes_l;
  logic [SW-1:0] step_idx;
  logic          busy;
  logic          inhibited;
  logic          gamma_done;
`ifdef FFI_STATS_EN
  logic [15:0]   inhib_count;
  logic [CW-1:0] last_count;
`endif

  ffi_gamma_scheduler dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .cfg_we       (cfg_we),
    .cfg_ffi_max  (cfg_ffi_max),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_spikes_l  (in_spikes_l),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_spikes_l (out_spikes_l),
    .step_idx     (step_idx),
    .busy         (busy),
    .inhibited    (inhibited),
    .gamma_done   (gamma_done)
`ifdef FFI_STATS_EN
    ,
    .inhib_count  (inhib_count),
    .last_count   (last_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: one gamma cycle = GL accepted volleys
  bit          m_busy, m_fired, m_ov, m_done;
  int          m_c, m_step, m_ffi, m_icnt, m_last;
  logic [15:0] m_out;

  task automatic model_reset();
    m_busy = 0; m_fired = 0; m_ov = 0; m_done = 0;
    m_c = 0; m_step = 0; m_ffi = 4;
    m_icnt = 0; m_last = 0; m_out = 16'hFFFF;
  endtask

  // Called at posedge+1; drives inputs, checks across the next edge
  task automatic cycle(input bit st, input bit we, input int val,
                       input bit iv, input logic [15:0] spk,
                       input bit orr);
    bit er, acc;
    int n;
    start = st; cfg_we = we; cfg_ffi_max = CW'(val);
    in_valid = iv; in_spikes_l = spk; out_ready = orr;
    #1;
    er = m_busy && (!m_ov || orr);
    chk("in_ready", 32'(in_ready), 32'(er));
    acc = iv && er;
    m_done = 0;
    if (!m_busy) begin
      if (we) m_ffi = val;
      if (st) begin
        m_busy = 1; m_c = 0; m_step = 0; m_fired = 0;
      end
    end else if (acc) begin
      n = NS - $countones(spk);
      if (!m_fired && (m_c + n < m_ffi)) begin
        m_out = spk;
        m_c += n;
      end else begin
        m_out = 16'hFFFF;
        m_fired = 1;
      end
      m_step++;
      if (m_step == GL) begin
        m_step = 0; m_busy = 0; m_done = 1; m_last = m_c;
        if (m_fired && m_icnt < 65535) m_icnt++;
      end
    end
    if (acc) m_ov = 1;
    else if (orr) m_ov = 0;
    @(posedge clk); #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) chk("out_spikes_l", 32'(out_spikes_l), 32'(m_out));
    chk("step_idx", 32'(step_idx), 32'(m_step));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("inhibited", 32'(inhibited), 32'(m_fired));
    chk("gamma_done", 32'(gamma_done), 32'(m_done));
`ifdef FFI_STATS_EN
    chk("inhib_count", 32'(inhib_count), 32'(m_icnt));
    chk("last_count", 32'(last_count), 32'(m_last));
`endif
  endtask

  task automatic volleys(input int k, input logic [15:0] spk);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 1, spk, 1);
  endtask

  typedef struct {
    bit          st;
    bit          iv;
    logic [15:0] spk;
    bit          ov;
    logic [15:0] out;
    bit          inh;
    bit          done;
    bit          bsy;
    int          step;
  } vec_t;

  vec_t tbl[10];
  logic [15:0] held;
  int dones;

  initial begin
    // threshold-fire vectors at the default threshold of 4
    tbl[0] = '{1, 0, 16'hFFFF, 0, 16'hFFFF, 0, 0, 1, 0};
    for (int k = 0; k < 8; k++) begin
      logic [15:0] s;
      s = ~(16'h0001 << k);
      tbl[k+1] = '{0, 1, s, 1, (k < 3) ? s : 16'hFFFF,
                   k >= 3, k == 7, k != 7, (k + 1) % 8};
    end
    tbl[9] = '{0, 0, 16'hFFFF, 0, 16'hFFFF, 1, 0, 0, 0};

    rst_l = 0; start = 0; cfg_we = 0; cfg_ffi_max = '0;
    in_valid = 0; in_spikes_l = '1; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_spikes", 32'(out_spikes_l), 32'hFFFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    #3 rst_l = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].st, 0, 0, tbl[i].iv, tbl[i].spk, 1);
      chk("tbl_ov", 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov)
        chk("tbl_out", 32'(out_spikes_l), 32'(tbl[i].out));
      chk("tbl_inh", 32'(inhibited), 32'(tbl[i].inh));
      chk("tbl_done", 32'(gamma_done), 32'(tbl[i].done));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].bsy));
      chk("tbl_step", 32'(step_idx), 32'(tbl[i].step));
    end

    // no fire: silent volleys pass, done pulses exactly once
    cycle(1, 0, 0, 0, 16'hFFFF, 1);
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, i < 8, 16'hFFFF, 1);
      if (gamma_done) dones++;
    end
    chk("nofire_inh", 32'(inhibited), 32'd0);
    chk("nofire_dones", 32'(dones), 32'd1);

    // backpressure
    cycle(1, 0, 0, 0, 16'hFFFF, 1);
    cycle(0, 0, 0, 1, 16'hFFFE, 1);
    held = out_spikes_l;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 16'hFFFD, 0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stable", 32'(out_spikes_l), 32'(held));
    end
    cycle(0, 0, 0, 1, 16'hFFFD, 1);
    chk("bp_ov_kept", 32'(out_valid), 32'd1);
    chk("bp_next", 32'(out_spikes_l), 32'hFFFD);
    volleys(6, 16'hFFFF);
    cycle(0, 0, 0, 0, 16'hFFFF, 1);

    // cfg write while running is ignored
    cycle(1, 0, 0, 0, 16'hFFFF, 1);
    cycle(0, 1, 2, 1, 16'hFFFE, 1);
    cycle(0, 0, 0, 1, 16'hFFFD, 1);
    chk("cfg_ignored", 32'(out_spikes_l), 32'hFFFD);
    volleys(6, 16'hFFFF);
    cycle(0, 0, 0, 0, 16'hFFFF, 1);

    // threshold 0 written with start fires on a silent volley
    cycle(1, 1, 0, 0, 16'hFFFF, 1);
    cycle(0, 0, 0, 1, 16'hFFFF, 1);
    chk("zero_out", 32'(out_spikes_l), 32'hFFFF);
    chk("zero_inh", 32'(inhibited), 32'd1);
    volleys(7, 16'hFFFE);
    cycle(0, 0, 0, 0, 16'hFFFF, 1);

    // async reset mid-RUN with a pending output
    cycle(1, 1, 3, 0, 16'hFFFF, 1);
    cycle(0, 0, 0, 1, 16'hFFF0, 0);
    chk("pre_rst_ov", 32'(out_valid), 32'd1);
    chk("pre_rst_inh", 32'(inhibited), 32'd1);
    #2 rst_l = 0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_out", 32'(out_spikes_l), 32'hFFFF);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_step", 32'(step_idx), 32'd0);
    chk("arst_inh", 32'(inhibited), 32'd0);
`ifdef FFI_STATS_EN
    chk("arst_icnt", 32'(inhib_count), 32'd0);
    chk("arst_last", 32'(last_count), 32'd0);
`endif
    @(posedge clk); #4 rst_l = 1;
    @(posedge clk); #1;
    model_reset();
    // default threshold of 4 is back after reset
    cycle(1, 0, 0, 0, 16'hFFFF, 1);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0, 1, 16'hFFFF ^ (16'h1 << k), 1);
      if (k == 2) chk("def4_pass", 32'(inhibited), 32'd0);
      if (k == 3) chk("def4_fire", 32'(inhibited), 32'd1);
    end
    cycle(0, 0, 0, 0, 16'hFFFF, 1);

`ifdef FFI_STATS_EN
    // three cycles, two inhibiting, counted from zero after reset
    rst_l = 0; #2; rst_l = 1;
    @(posedge clk); #1;
    model_reset();
    cycle(1, 0, 0, 0, 16'hFFFF, 1);
    volleys(8, 16'hFFF0);
    cycle(1, 0, 0, 0, 16'hFFFF, 1);
    volleys(8, 16'hFFFF);
    cycle(1, 0, 0, 0, 16'hFFFF, 1);
    volleys(2, 16'hFFFE);
    volleys(6, 16'hFFF0);
    cycle(0, 0, 0, 0, 16'hFFFF, 1);
    chk("stats_icnt", 32'(inhib_count), 32'd2);
    chk("stats_last", 32'(last_count), 32'd2);
`endif

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] s;
      s = 16'($urandom | $urandom | $urandom);
      cycle($urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 12)),
            $urandom_range(0, 3) != 0,
            s,
            $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
